// File: rtl/regbank_arbiter_if.sv
// Bus bundle between two requesters and the register-bank arbiter.
// Signals:
//   req_x/we_x/addr_x/wdata_x : per-requester access request and payload
//   gnt_a/gnt_b               : one-cycle completion pulses
//   rdata                     : last read result
//   busy                      : sequencer not idle
//   dbg_addr/dbg_data         : debug peek into the bank
// Modports: master = requester/debug side, slave = arbiter side.
interface regbank_arbiter_if;
    logic       req_a;
    logic       we_a;
    logic [1:0] addr_a;
    logic [7:0] wdata_a;
    logic       req_b;
    logic       we_b;
    logic [1:0] addr_b;
    logic [7:0] wdata_b;
    logic       gnt_a;
    logic       gnt_b;
    logic [7:0] rdata;
    logic       busy;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output dbg_addr,
        input  gnt_a, gnt_b, rdata, busy, dbg_data
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  dbg_addr,
        output gnt_a, gnt_b, rdata, busy, dbg_data
    );
endinterface

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter giving two requesters access to a 4 x 8-bit register
// bank through one port. A winner is latched in IDLE, its access runs in
// EXEC, and a one-cycle grant pulse is issued in ACK.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : regbank_arbiter_if.slave (requests, grants, rdata, busy, debug)
module regbank_arbiter (
    input  logic                  clk,
    input  logic                  rst,
    regbank_arbiter_if.slave      bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ACK  = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                win;
    logic                latch;
    logic                rd_en;
    logic [DEPTH-1:0]    bank_en;

    logic                hold_id_q;
    logic                hold_we_q;
    logic [ADDR_W-1:0]   hold_addr_q;
    logic [DATA_W-1:0]   hold_wdata_q;

    logic [DATA_W-1:0]   bank_q [DEPTH];
    logic [DATA_W-1:0]   rdata_q;
    logic                gnt_a_q, gnt_b_q, busy_q;

    // Next-state, winner selection and bank access strobes
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        latch   = 1'b0;
        rd_en   = 1'b0;
        bank_en = '0;
        // On a tie the requester that did not win last time goes next
        if (bus.req_a && bus.req_b) begin
            win = ~last_q;
        end else if (bus.req_b) begin
            win = SEL_B;
        end else begin
            win = SEL_A;
        end

        case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    latch   = 1'b1;
                    last_d  = win;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (hold_we_q) begin
                    bank_en[hold_addr_q] = 1'b1;
                end else begin
                    rd_en = 1'b1;
                end
                state_d = ACK;
            end
            ACK: begin
                // Requests deliberately ignored here
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, round-robin history and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SEL_B;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            // Grant/busy follow the next state so they line up with ACK/EXEC
            gnt_a_q <= (state_d == ACK) && (hold_id_q == SEL_A);
            gnt_b_q <= (state_d == ACK) && (hold_id_q == SEL_B);
            busy_q  <= (state_d != IDLE);
        end
    end

    // Holding registers isolate the in-flight access from request changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_id_q    <= SEL_A;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else if (latch) begin
            hold_id_q    <= win;
            hold_we_q    <= (win == SEL_B) ? bus.we_b    : bus.we_a;
            hold_addr_q  <= (win == SEL_B) ? bus.addr_b  : bus.addr_a;
            hold_wdata_q <= (win == SEL_B) ? bus.wdata_b : bus.wdata_a;
        end
    end

    // Register bank with per-entry write enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (bank_en[i]) begin
                    bank_q[i] <= hold_wdata_q;
                end
            end
        end
    end

    // Read data holds until the next completed read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= bank_q[hold_addr_q];
        end
    end

    assign bus.gnt_a    = gnt_a_q;
    assign bus.gnt_b    = gnt_b_q;
    assign bus.busy     = busy_q;
    assign bus.rdata    = rdata_q;
    assign bus.dbg_data = bank_q[bus.dbg_addr];

endmodule

// File: tb/tb_regbank_arbiter.sv
// Scoreboard bench for regbank_arbiter: stimulus pushes expected grants into
// a queue, a negedge monitor pops and compares on every grant pulse.
module tb_regbank_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    typedef struct {
        logic       who;
        logic       chk;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    regbank_arbiter_if bus ();

    regbank_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check8(name, 8'(act), 8'(exp));
    endtask

    task automatic check_bank(input logic [1:0] idx, input logic [7:0] exp);
        bus.dbg_addr = idx;
        #1;
        check8($sformatf("bank[%0d]", idx), bus.dbg_data, exp);
    endtask

    // Monitor: every grant pulse must match the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.gnt_a || bus.gnt_b)) begin
                if (bus.gnt_a && bus.gnt_b) begin
                    check1("dual_grant", 1'b1, 1'b0);
                end else if (exp_q.size() == 0) begin
                    check1("unexpected_grant", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check1("grant_owner", bus.gnt_b, e.who);
                    if (e.chk) check8("grant_rdata", bus.rdata, e.rdata);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One access by a single requester; returns cycles from request to grant
    task automatic access(input logic who, input logic we, input logic [1:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd,
                          input bit mutate, output int lat);
        bit seen;
        exp_q.push_back('{who, ~we, exp_rd});
        if (who) begin
            bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata;
        end else begin
            bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata;
        end
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (mutate && lat == 1) begin
                if (who) begin bus.wdata_b = 8'hFF; bus.addr_b = 2'd0; end
                else     begin bus.wdata_a = 8'hFF; bus.addr_a = 2'd0; end
            end
            if (who ? bus.gnt_b : bus.gnt_a) begin
                seen = 1'b1;
                break;
            end
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        check1("grant_seen", seen, 1'b1);
    endtask

    initial begin
        int lat;
        int t_a, t_b;
        bit got_a, got_b;
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
        bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
        bus.dbg_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check1("rst_gnt_a", bus.gnt_a, 1'b0);
        check1("rst_gnt_b", bus.gnt_b, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check8("rst_rdata", bus.rdata, 8'h00);
        for (int i = 0; i < 4; i++) check_bank(2'(i), 8'h00);
        rst = 1'b0;

        // Reset during EXEC drops the write and the grant
        @(negedge clk);
        bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 2'd1; bus.wdata_a = 8'h5A;
        @(negedge clk);
        check1("exec_busy", bus.busy, 1'b1);
        rst = 1'b1;
        bus.req_a = 1'b0;
        #1;
        check1("midrst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_bank(2'd1, 8'h00);
        check8("midrst_rdata", bus.rdata, 8'h00);
        check1("midrst_idle", bus.busy, 1'b0);

        // Single write then read
        access(1'b0, 1'b1, 2'd2, 8'hC3, 8'h00, 1'b0, lat);
        check8("wr_latency", 8'(lat), 8'd2);
        check_bank(2'd2, 8'hC3);
        @(negedge clk);
        access(1'b0, 1'b0, 2'd2, 8'h00, 8'hC3, 1'b0, lat);

        // Tie right after reset: A then B, three cycles apart
        do_reset();
        exp_q.push_back('{1'b0, 1'b0, 8'h00});
        exp_q.push_back('{1'b1, 1'b0, 8'h00});
        bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 2'd0; bus.wdata_a = 8'h11;
        bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 2'd0; bus.wdata_b = 8'h22;
        t_a = 0; t_b = 0; got_a = 1'b0; got_b = 1'b0;
        for (int i = 1; i <= 20 && !got_b; i++) begin
            @(negedge clk);
            if (bus.gnt_a && !got_a) begin got_a = 1'b1; t_a = i; bus.req_a = 1'b0; end
            if (bus.gnt_b && !got_b) begin got_b = 1'b1; t_b = i; bus.req_b = 1'b0; end
        end
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        check1("tie_a_first", got_a && (t_a < t_b), 1'b1);
        check8("tie_a_lat", 8'(t_a), 8'd2);
        check8("tie_spacing", 8'(t_b - t_a), 8'd3);
        check_bank(2'd0, 8'h22);

        // Sustained contention: alternating reads, one access every 3 cycles
        @(negedge clk);
        exp_q.push_back('{1'b0, 1'b1, 8'h22});
        exp_q.push_back('{1'b1, 1'b1, 8'h22});
        exp_q.push_back('{1'b0, 1'b1, 8'h22});
        exp_q.push_back('{1'b1, 1'b1, 8'h22});
        bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 2'd0;
        bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 2'd0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 12) begin bus.req_a = 1'b0; bus.req_b = 1'b0; end
            check1($sformatf("sus_busy_%0d", i), bus.busy, (i % 3) != 0);
            check1($sformatf("sus_gnt_%0d", i), bus.gnt_a | bus.gnt_b, (i % 3) == 2);
        end
        @(negedge clk);

        // Input change after latch has no effect on the access
        access(1'b1, 1'b1, 2'd3, 8'h7E, 8'h00, 1'b1, lat);
        check_bank(2'd3, 8'h7E);
        check_bank(2'd0, 8'h22);
        check_bank(2'd1, 8'h00);
        check_bank(2'd2, 8'h00);

        // Write isolation: preload, set rdata, then one write
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            access(1'b0, 1'b1, 2'(i), 8'(i + 1), 8'h00, 1'b0, lat);
        end
        @(negedge clk);
        access(1'b1, 1'b0, 2'd3, 8'h00, 8'h04, 1'b0, lat);
        @(negedge clk);
        access(1'b0, 1'b1, 2'd1, 8'hAA, 8'h00, 1'b0, lat);
        check_bank(2'd0, 8'h01);
        check_bank(2'd1, 8'hAA);
        check_bank(2'd2, 8'h03);
        check_bank(2'd3, 8'h04);
        check8("iso_rdata_hold", bus.rdata, 8'h04);

        repeat (4) @(negedge clk);
        check8("pending_exp", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
